// File: rtl/instr_buffer.sv
// Fetch-side instruction queue: packs up to four valid slots per cycle
// into a circular buffer and presents the two oldest entries to decode.
module instr_buffer #(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [127:0]     enq_instr,
  input  logic [3:0]       enq_instr_valid,
  input  logic [63:0]      enq_pc,
  output logic             deq0_valid,
  output logic [31:0]      deq0_instr,
  output logic [63:0]      deq0_pc,
  output logic             deq1_valid,
  output logic [31:0]      deq1_instr,
  output logic [63:0]      deq1_pc,
  input  logic             deq_ready,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] ROOM4 =
    (PTR_W+1)'(DEPTH - 4);

  logic [31:0]      mem_instr [DEPTH];
  logic [63:0]      mem_pc    [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd1;
  logic [PTR_W-1:0] widx [4];
  logic [PTR_W:0]   cnt;
  logic [PTR_W:0]   n_eff;
  logic [PTR_W:0]   m_eff;
  logic [2:0]       n;
  logic [2:0]       off [4];
  logic [1:0]       m;
  logic             enq_fire;
  logic             deq_fire;

  assign count      = cnt;
  assign enq_ready  = cnt <= ROOM4;
  assign deq0_valid = cnt != '0;
  assign deq1_valid = cnt > (PTR_W+1)'(1);

  assign rd1        = rd_ptr + PTR_W'(1);
  assign deq0_instr = mem_instr[rd_ptr];
  assign deq0_pc    = mem_pc[rd_ptr];
  assign deq1_instr = mem_instr[rd1];
  assign deq1_pc    = mem_pc[rd1];

  assign enq_fire = enq_valid & enq_ready & ~flush;
  assign deq_fire = deq_ready & ~flush;

  // Each valid slot lands at wr_ptr plus the number of valid slots below it
  always_comb begin
    n = '0;
    for (int i = 0; i < 4; i++) begin
      off[i]  = n;
      widx[i] = wr_ptr + PTR_W'(n);
      n       = n + {2'b00, enq_instr_valid[i]};
    end
  end

  assign m     = {1'b0, deq0_valid} + {1'b0, deq1_valid};
  assign n_eff = enq_fire ? (PTR_W+1)'(n) : '0;
  assign m_eff = deq_fire ? (PTR_W+1)'(m) : '0;

  always_ff @(posedge clock) begin
    if (enq_fire) begin
      for (int i = 0; i < 4; i++) begin
        if (enq_instr_valid[i]) begin
          mem_instr[widx[i]] <= enq_instr[32*i +: 32];
          mem_pc[widx[i]]    <= enq_pc + 64'(4*i);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      wr_ptr <= wr_ptr + n_eff[PTR_W-1:0];
      rd_ptr <= rd_ptr + m_eff[PTR_W-1:0];
      cnt    <= cnt + n_eff - m_eff;
    end
  end

endmodule
